accum_ctrl: RTL and testbench

ACCUM_CTRL -- requirements
Module: accum_ctrl

---
 rtl/accum_pkg.sv | 18 +
 rtl/wrap_cnt.sv | 45 ++++
 rtl/accum_ctrl.sv | 164 ++++++++++++++++
 tb/tb_accum_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator-column controller.
// Holds the controller state encoding, default address/data widths and the
// fixed pass-counter width.
package accum_pkg;

  localparam int unsigned ACC_ADDR_W = 4;
  localparam int unsigned ACC_DATA_W = 8;
  localparam int unsigned PASS_W     = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/wrap_cnt.sv
// Wrapping up-counter with a runtime limit.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : synchronous clear to zero (wins over en_i)
//   en_i          : increment enable
//   limit_i       : last count value before wrapping to zero
//   cnt_o         : current count
//   wrap_o        : high when an increment at the limit occurs this cycle
module wrap_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         at_limit;

  assign at_limit = (cnt_q == limit_i);
  assign wrap_o   = en_i & at_limit;
  assign cnt_o    = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_limit ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/accum_ctrl.sv
// Controller for an external accumulator column.
// A job clears the column, accumulates (rows_m1+1)*(passes_m1+1) partial sums
// row by row, then drains every row through a valid/ready output.
// Ports:
//   clock, reset                 : clock, asynchronous active-low reset
//   io_start, io_rows_m1,
//   io_passes_m1                 : job request and its configuration
//   io_in_valid/ready/data       : partial-sum input stream
//   io_out_valid/ready/data      : drained result stream
//   io_acc_clear/wr_en/rd_en,
//   io_acc_wr_addr/rd_addr,
//   io_acc_wr_data, io_acc_rd_data : accumulator column interface
//   io_busy, io_done             : status (done is a single-cycle pulse)
module accum_ctrl
  import accum_pkg::*;
#(
  parameter int unsigned ADDR_W = ACC_ADDR_W,
  parameter int unsigned DATA_W = ACC_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_start,
  input  logic [ADDR_W-1:0] io_rows_m1,
  input  logic [PASS_W-1:0] io_passes_m1,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [DATA_W-1:0] io_in_data,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [DATA_W-1:0] io_out_data,
  output logic              io_acc_clear,
  output logic              io_acc_wr_en,
  output logic              io_acc_rd_en,
  output logic [ADDR_W-1:0] io_acc_wr_addr,
  output logic [ADDR_W-1:0] io_acc_rd_addr,
  output logic [DATA_W-1:0] io_acc_wr_data,
  input  logic [DATA_W-1:0] io_acc_rd_data,
  output logic              io_busy,
  output logic              io_done
);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] rows_m1_q, rows_m1_d;
  logic [PASS_W-1:0] passes_m1_q, passes_m1_d;

  logic              cnt_clr;
  logic              accept;
  logic              drain_fire;
  logic [ADDR_W-1:0] row_cnt;
  logic              row_wrap;
  logic [PASS_W-1:0] pass_cnt;
  logic              pass_wrap;
  logic [ADDR_W-1:0] drain_cnt;
  logic              drain_wrap;

  // Only the pass counter's wrap flag matters; its value is never observed.
  logic unused_pass_cnt;
  assign unused_pass_cnt = ^pass_cnt;

  assign accept     = (state_q == ACCUM) & io_in_valid;
  assign drain_fire = (state_q == DRAIN) & io_out_ready;
  assign cnt_clr    = (state_q == IDLE) | (state_q == CLEAR);

  wrap_cnt #(.W(ADDR_W)) u_row_cnt (
    .clk_i   (clock),
    .rst_ni  (reset),
    .clr_i   (cnt_clr),
    .en_i    (accept),
    .limit_i (rows_m1_q),
    .cnt_o   (row_cnt),
    .wrap_o  (row_wrap)
  );

  // Advances once per completed sweep over all rows; its wrap marks the
  // final beat of the whole accumulation phase.
  wrap_cnt #(.W(PASS_W)) u_pass_cnt (
    .clk_i   (clock),
    .rst_ni  (reset),
    .clr_i   (cnt_clr),
    .en_i    (row_wrap),
    .limit_i (passes_m1_q),
    .cnt_o   (pass_cnt),
    .wrap_o  (pass_wrap)
  );

  wrap_cnt #(.W(ADDR_W)) u_drain_cnt (
    .clk_i   (clock),
    .rst_ni  (reset),
    .clr_i   (cnt_clr),
    .en_i    (drain_fire),
    .limit_i (rows_m1_q),
    .cnt_o   (drain_cnt),
    .wrap_o  (drain_wrap)
  );

  // Configuration is captured only when a start is accepted.
  always_comb begin
    rows_m1_d   = rows_m1_q;
    passes_m1_d = passes_m1_q;
    if ((state_q == IDLE) && io_start) begin
      rows_m1_d   = io_rows_m1;
      passes_m1_d = io_passes_m1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (io_start) state_d = CLEAR;
      CLEAR:   state_d = ACCUM;
      ACCUM:   if (pass_wrap) state_d = DRAIN;
      DRAIN:   if (drain_wrap) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    io_in_ready    = 1'b0;
    io_out_valid   = 1'b0;
    io_out_data    = '0;
    io_acc_clear   = 1'b0;
    io_acc_wr_en   = 1'b0;
    io_acc_rd_en   = 1'b0;
    io_acc_wr_addr = '0;
    io_acc_rd_addr = '0;
    io_acc_wr_data = '0;
    io_busy        = (state_q != IDLE);
    io_done        = 1'b0;
    unique case (state_q)
      CLEAR: io_acc_clear = 1'b1;
      ACCUM: begin
        io_in_ready    = 1'b1;
        io_acc_wr_en   = accept;
        io_acc_wr_addr = row_cnt;
        io_acc_wr_data = io_in_data;
      end
      // Read data is combinational from the column, so holding the drain
      // address during a stall keeps io_out_data stable.
      DRAIN: begin
        io_acc_rd_en   = 1'b1;
        io_acc_rd_addr = drain_cnt;
        io_out_valid   = 1'b1;
        io_out_data    = io_acc_rd_data;
      end
      DONE:    io_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rows_m1_q   <= '0;
      passes_m1_q <= '0;
    end else begin
      state_q     <= state_d;
      rows_m1_q   <= rows_m1_d;
      passes_m1_q <= passes_m1_d;
    end
  end

endmodule

// File: tb/tb_accum_ctrl.sv
module tb_accum_ctrl;

  logic             clock = 1'b0;
  logic             reset;
  logic             io_start;
  logic [3:0]       io_rows_m1;
  logic [7:0]       io_passes_m1;
  logic             io_in_valid;
  logic             io_in_ready;
  logic [7:0]       io_in_data;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [7:0]       io_out_data;
  logic             io_acc_clear;
  logic             io_acc_wr_en;
  logic             io_acc_rd_en;
  logic [3:0]       io_acc_wr_addr;
  logic [3:0]       io_acc_rd_addr;
  logic [7:0]       io_acc_wr_data;
  logic [7:0]       io_acc_rd_data;
  logic             io_busy;
  logic             io_done;

  always #5 clock = ~clock;

  accum_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .io_start       (io_start),
    .io_rows_m1     (io_rows_m1),
    .io_passes_m1   (io_passes_m1),
    .io_in_valid    (io_in_valid),
    .io_in_ready    (io_in_ready),
    .io_in_data     (io_in_data),
    .io_out_valid   (io_out_valid),
    .io_out_ready   (io_out_ready),
    .io_out_data    (io_out_data),
    .io_acc_clear   (io_acc_clear),
    .io_acc_wr_en   (io_acc_wr_en),
    .io_acc_rd_en   (io_acc_rd_en),
    .io_acc_wr_addr (io_acc_wr_addr),
    .io_acc_rd_addr (io_acc_rd_addr),
    .io_acc_wr_data (io_acc_wr_data),
    .io_acc_rd_data (io_acc_rd_data),
    .io_busy        (io_busy),
    .io_done        (io_done)
  );

  // Behavioural accumulator column: clear zeroes, write adds, read is combinational.
  logic [7:0] mem [16];
  always @(posedge clock) begin
    if (io_acc_clear) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'd0;
    end else if (io_acc_wr_en) begin
      mem[io_acc_wr_addr] <= mem[io_acc_wr_addr] + io_acc_wr_data;
    end
  end
  assign io_acc_rd_data = mem[io_acc_rd_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return {1'b0, io_busy, io_done, io_in_ready, io_out_valid, io_acc_clear,
            io_acc_wr_en, io_acc_rd_en, io_acc_wr_addr, io_acc_rd_addr,
            io_acc_wr_data, io_out_data};
  endfunction

  typedef struct packed {
    logic [3:0]       rows_m1;
    logic [7:0]       passes_m1;
    logic [15:0][7:0] row_val;
    logic [15:0][7:0] exp_val;
    logic             toggle;
    logic             stall;
    logic             start_poke;
    logic [31:0]      lat;
  } job_t;

  function automatic job_t mk(input logic [3:0] r, input logic [7:0] p,
                              input logic [3:0][7:0] v4, input logic [7:0] vfill,
                              input logic [3:0][7:0] e4, input logic [7:0] efill,
                              input logic tog, input logic stl, input logic poke,
                              input logic [31:0] lat);
    job_t j;
    j.rows_m1   = r;
    j.passes_m1 = p;
    for (int i = 0; i < 16; i++) begin
      j.row_val[i] = (i < 4) ? v4[i] : vfill;
      j.exp_val[i] = (i < 4) ? e4[i] : efill;
    end
    j.toggle     = tog;
    j.stall      = stl;
    j.start_poke = poke;
    j.lat        = lat;
    return j;
  endfunction

  task automatic run_job(input job_t j, input string tag);
    int rows, total, beats, row, guard, cyc, d, stalls;
    logic tog;
    rows  = int'(j.rows_m1);
    total = (rows + 1) * (int'(j.passes_m1) + 1);
    @(negedge clock);
    io_rows_m1   = j.rows_m1;
    io_passes_m1 = j.passes_m1;
    io_start     = 1'b1;
    #1 check({tag, " idle_busy"}, io_busy, 0);
    @(negedge clock);
    io_start = 1'b0;
    cyc = 1;
    #1;
    check({tag, " clear_pulse"}, io_acc_clear, 1);
    check({tag, " clear_ready"}, io_in_ready, 0);
    beats = 0; row = 0; guard = 0; tog = 1'b1;
    while (beats < total && guard < 4000) begin
      @(negedge clock);
      cyc++; guard++;
      io_in_valid = j.toggle ? tog : 1'b1;
      tog         = ~tog;
      io_in_data  = j.row_val[row];
      io_start    = j.start_poke && (beats == 2);
      #1;
      check({tag, " acc_ready"}, io_in_ready, 1);
      check({tag, " acc_wr_en"}, io_acc_wr_en, io_in_valid);
      if (io_in_valid) begin
        check({tag, " acc_wr_addr"}, io_acc_wr_addr, row);
        check({tag, " acc_wr_data"}, io_acc_wr_data, j.row_val[row]);
        beats++;
        row = (row == rows) ? 0 : row + 1;
      end
    end
    if (guard >= 4000) check({tag, " accum_timeout"}, beats, total);
    // First drain cycle; keep offering input to show it is refused.
    @(negedge clock);
    cyc++;
    io_start    = 1'b0;
    io_in_valid = 1'b1;
    d = 0; stalls = 0; guard = 0;
    while (d <= rows && guard < 200) begin
      guard++;
      io_out_ready = !(j.stall && d == 1 && stalls < 3);
      #1;
      check({tag, " drain_valid"}, io_out_valid, 1);
      check({tag, " drain_in_ready"}, io_in_ready, 0);
      check({tag, " drain_wr_en"}, io_acc_wr_en, 0);
      check({tag, " drain_rd_addr"}, io_acc_rd_addr, d);
      check({tag, " drain_data"}, io_out_data, j.exp_val[d]);
      if (io_out_ready) d++;
      else stalls++;
      @(negedge clock);
      cyc++;
    end
    if (guard >= 200) check({tag, " drain_timeout"}, d, rows + 1);
    io_in_valid  = 1'b0;
    io_out_ready = 1'b0;
    #1;
    check({tag, " done_pulse"}, io_done, 1);
    check({tag, " done_out_valid"}, io_out_valid, 0);
    if (j.lat != 0) check({tag, " latency"}, cyc, j.lat);
    @(negedge clock);
    #1;
    check({tag, " done_low"}, io_done, 0);
    check({tag, " back_idle"}, io_busy, 0);
  endtask

  job_t jobs [8];
  int   done_seen;

  initial begin
    jobs[0] = mk(4'd3,  8'd0, {8'd4, 8'd3, 8'd2, 8'd1},         8'd0,
                              {8'd4, 8'd3, 8'd2, 8'd1},         8'd0,   1'b0, 1'b0, 1'b0, 32'd10);
    jobs[1] = mk(4'd1,  8'd2, {8'd0, 8'd0, 8'd7, 8'd5},         8'd0,
                              {8'd0, 8'd0, 8'd21, 8'd15},       8'd0,   1'b0, 1'b0, 1'b0, 32'd10);
    jobs[2] = jobs[1];
    jobs[3] = mk(4'd15, 8'd1, {8'd200, 8'd200, 8'd200, 8'd200}, 8'd200,
                              {8'd144, 8'd144, 8'd144, 8'd144}, 8'd144, 1'b0, 1'b0, 1'b0, 32'd50);
    jobs[4] = mk(4'd3,  8'd1, {8'd40, 8'd30, 8'd20, 8'd10},     8'd0,
                              {8'd80, 8'd60, 8'd40, 8'd20},     8'd0,   1'b1, 1'b1, 1'b1, 32'd0);
    jobs[5] = mk(4'd0,  8'd0, {8'd0, 8'd0, 8'd0, 8'd99},        8'd0,
                              {8'd0, 8'd0, 8'd0, 8'd99},        8'd0,   1'b0, 1'b0, 1'b0, 32'd4);
    jobs[6] = mk(4'd0,  8'd3, {8'd0, 8'd0, 8'd0, 8'd60},        8'd0,
                              {8'd0, 8'd0, 8'd0, 8'd240},       8'd0,   1'b0, 1'b0, 1'b0, 32'd7);
    jobs[7] = mk(4'd2,  8'd1, {8'd0, 8'd130, 8'd100, 8'd250},   8'd0,
                              {8'd0, 8'd4, 8'd200, 8'd244},     8'd0,   1'b0, 1'b0, 1'b0, 32'd11);

    reset        = 1'b0;
    io_start     = 1'b1;
    io_rows_m1   = 4'd5;
    io_passes_m1 = 8'd5;
    io_in_valid  = 1'b1;
    io_in_data   = 8'hAA;
    io_out_ready = 1'b1;
    #3 check("reset_outputs", outs_vec(), 0);
    @(negedge clock);
    @(negedge clock);
    io_start = 1'b0; io_in_valid = 1'b0; io_out_ready = 1'b0;
    reset = 1'b1;

    for (int k = 0; k < 4; k++) run_job(jobs[k], $sformatf("job%0d", k));

    // Abort a job mid-accumulation with an asynchronous reset.
    @(negedge clock);
    io_rows_m1 = 4'd3; io_passes_m1 = 8'd1; io_start = 1'b1;
    @(negedge clock);
    io_start = 1'b0; io_in_valid = 1'b1; io_in_data = 8'd9;
    repeat (4) @(negedge clock);
    #1 check("abort_busy_before", io_busy, 1);
    #1 reset = 1'b0;
    #1 check("abort_outputs", outs_vec(), 0);
    @(negedge clock);
    reset = 1'b1; io_in_valid = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      #1 if (io_done || io_busy) done_seen++;
    end
    check("abort_no_done", done_seen, 0);

    for (int k = 7; k >= 4; k--) run_job(jobs[k], $sformatf("job%0d", k));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
